// File: rtl/dp_data_arbiter_pkg.sv
// Shared types and constants for the display processor data-memory arbiter.
package dp_data_arbiter_pkg;

    localparam int NUM_DP_REQ = 2;

    // Requester ids, also used as bit indices into req/gnt/rd_valid.
    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_HOST = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // One entry per issued access; valid marks a read whose data must be returned.
    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

    function automatic arb_state_t own_state(input logic id);
        return id ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/dp_data_arbiter_if.sv
// Requester and memory-side signals of the data arbiter.
interface dp_data_arbiter_if;
    import dp_data_arbiter_pkg::*;

    logic [NUM_DP_REQ-1:0] req;
    logic [31:0]           req_addr0;
    logic [31:0]           req_addr1;
    logic [31:0]           req_wr_data0;
    logic [31:0]           req_wr_data1;
    logic [3:0]            req_wr_en0;
    logic [3:0]            req_wr_en1;
    logic [NUM_DP_REQ-1:0] gnt;
    logic [NUM_DP_REQ-1:0] rd_valid;
    logic [31:0]           rd_data;
    logic [31:0]           mem_addr;
    logic [31:0]           mem_wr_data;
    logic [3:0]            mem_wr_en;
    logic [31:0]           mem_rd_data;

    // Arbiter side.
    modport slave (
        input  req, req_addr0, req_addr1, req_wr_data0, req_wr_data1,
               req_wr_en0, req_wr_en1, mem_rd_data,
        output gnt, rd_valid, rd_data, mem_addr, mem_wr_data, mem_wr_en
    );

    // Requesters plus memory, as seen from outside the arbiter.
    modport master (
        output req, req_addr0, req_addr1, req_wr_data0, req_wr_data1,
               req_wr_en0, req_wr_en1, mem_rd_data,
        input  gnt, rd_valid, rd_data, mem_addr, mem_wr_data, mem_wr_en
    );

endinterface

// File: rtl/dp_data_arbiter_rd_tag_pipe.sv
// Delay line carrying {valid, id} of each issued access alongside the memory read latency.
module dp_data_arbiter_rd_tag_pipe
    import dp_data_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    reset,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t [DEPTH-1:0] stages;

    // Shift one stage per cycle; reset drops every in-flight tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            stages <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                stages[i] <= stages[i-1];
            end
            stages[0] <= tag_in;
        end
    end

    assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/dp_data_arbiter.sv
// Two-requester arbiter for the display processor data BRAM with bounded-burst round robin.
//
//   state | meaning
//   IDLE  | nobody owns the port; next grant goes to the lone requester, or to ~last if both ask
//   OWN0  | requester 0 (core) holds the port; burst_cnt counts its consecutive grants
//   OWN1  | requester 1 (host) holds the port; burst_cnt counts its consecutive grants
module dp_data_arbiter
    import dp_data_arbiter_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int MAX_BURST    = 16
) (
    input  logic               clk,
    input  logic               reset,
    dp_data_arbiter_if.slave   bus
);

    localparam int               CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] BURST_ONE = CNT_W'(1);

    arb_state_t            state, state_d;
    logic                  last, last_d;
    logic [CNT_W-1:0]      burst_cnt, burst_d;
    logic [NUM_DP_REQ-1:0] gnt_c;
    logic                  sel;
    logic                  owner;
    logic [3:0]            sel_wr_en;
    rd_tag_t               tag_in, tag_out;

    // Arbitration state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last      <= REQ_HOST;
            burst_cnt <= '0;
        end else begin
            state     <= state_d;
            last      <= last_d;
            burst_cnt <= burst_d;
        end
    end

    // Grant decision and next state; grants are combinational so there is no request latency.
    always_comb begin
        state_d = state;
        last_d  = last;
        burst_d = burst_cnt;
        gnt_c   = '0;
        sel     = REQ_CORE;
        owner   = (state == OWN1) ? REQ_HOST : REQ_CORE;
        case (state)
            IDLE: begin
                if (bus.req != '0) begin
                    sel          = (bus.req == 2'b11) ? ~last : bus.req[REQ_HOST];
                    gnt_c[sel]   = 1'b1;
                    state_d      = own_state(sel);
                    burst_d      = BURST_ONE;
                end
            end
            OWN0, OWN1: begin
                // The burst limit only bites while the other side is waiting.
                if (bus.req[owner] && (!bus.req[~owner] || burst_cnt < BURST_MAX)) begin
                    sel        = owner;
                    gnt_c[sel] = 1'b1;
                    if (burst_cnt != BURST_MAX) begin
                        burst_d = burst_cnt + BURST_ONE;
                    end
                end else if (bus.req[~owner]) begin
                    sel        = ~owner;
                    gnt_c[sel] = 1'b1;
                    state_d    = own_state(~owner);
                    burst_d    = BURST_ONE;
                    last_d     = owner;
                end else begin
                    state_d = IDLE;
                    last_d  = owner;
                    burst_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            gnt_c = '0;
        end
    end

    // Memory port mux and read-tag generation for the granted requester.
    always_comb begin
        bus.mem_addr    = '0;
        bus.mem_wr_data = '0;
        bus.mem_wr_en   = '0;
        tag_in          = '0;
        sel_wr_en       = sel ? bus.req_wr_en1 : bus.req_wr_en0;
        if (gnt_c != '0) begin
            bus.mem_addr    = sel ? bus.req_addr1 : bus.req_addr0;
            bus.mem_wr_data = sel ? bus.req_wr_data1 : bus.req_wr_data0;
            bus.mem_wr_en   = sel_wr_en;
            tag_in.valid    = (sel_wr_en == 4'h0);
            tag_in.id       = sel;
        end
    end

    dp_data_arbiter_rd_tag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // Read return; gated by reset so a tag still in the last stage never escapes.
    always_comb begin
        bus.rd_valid = '0;
        if (tag_out.valid && !reset) begin
            bus.rd_valid[tag_out.id] = 1'b1;
        end
    end

    assign bus.gnt     = gnt_c;
    assign bus.rd_data = bus.mem_rd_data;

endmodule
